// File: rtl/ac_rle_scheduler.sv
// rtl/ac_rle_scheduler.sv - baseline JPEG AC run/size symbol scheduler with ZRL/EOB insertion
// One coefficient per handshake in, one (run,size,amp,last) symbol per handshake out.
module ac_rle_scheduler (
   input  logic               clk_in,
   input  logic               rst_in_n,
   input  logic signed [10:0] coef_in,
   input  logic               coef_valid_in,
   output logic               coef_ready_out,
   output logic [3:0]         sym_run_out,
   output logic [3:0]         sym_size_out,
   output logic [9:0]         sym_amp_out,
   output logic               sym_last_out,
   output logic               sym_valid_out,
   input  logic               sym_ready_in,
   output logic [7:0]         lut_value_out,
   output logic [7:0]         lut_count_out
);

   typedef enum logic [1:0] {S_ACCEPT, S_ZRL, S_EMIT} state_t;

   state_t      state;
   logic [5:0]  idx;
   logic [5:0]  run;
   logic [3:0]  pend_size;
   logic [9:0]  pend_amp;
   logic        pend_last;

   logic        slot_free;
   logic [10:0] c_raw;
   logic [10:0] c;
   logic [9:0]  mag;
   logic [9:0]  amp_raw;
   logic [9:0]  amp_mask;
   logic [9:0]  cur_amp;
   logic [3:0]  cur_size;
   logic        coef_zero;
   logic        idx_last;
   logic [5:0]  idx_next;

   assign c_raw          = coef_in;
   assign slot_free      = !sym_valid_out || sym_ready_in;
   assign coef_ready_out = (state == S_ACCEPT) && slot_free;
   assign lut_value_out  = {4'b0, sym_run_out};
   assign lut_count_out  = {4'b0, sym_size_out};
   assign coef_zero      = (c_raw == 11'h000);
   assign idx_last       = (idx == 6'd63);
   assign idx_next       = idx_last ? 6'd1 : 6'(idx + 6'd1);

   // -1024 has no 10-bit category, so it is folded onto -1023 before sizing.
   always_comb begin
      c        = (c_raw == 11'h400) ? 11'h401 : c_raw;
      mag      = c[10] ? 10'(~c[9:0] + 10'd1) : c[9:0];
      amp_raw  = c[10] ? 10'(c[9:0] - 10'd1) : c[9:0];
      cur_size = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (mag[i]) cur_size = 4'(i + 1);
      end
      amp_mask = 10'((11'd1 << cur_size) - 11'd1);
      cur_amp  = amp_raw & amp_mask;
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state         <= S_ACCEPT;
         idx           <= 6'd1;
         run           <= 6'd0;
         pend_size     <= 4'd0;
         pend_amp      <= 10'd0;
         pend_last     <= 1'b0;
         sym_run_out   <= 4'd0;
         sym_size_out  <= 4'd0;
         sym_amp_out   <= 10'd0;
         sym_last_out  <= 1'b0;
         sym_valid_out <= 1'b0;
      end else begin
         // A free slot empties unless one of the branches below reloads it.
         if (slot_free) sym_valid_out <= 1'b0;
         case (state)
            S_ACCEPT: begin
               if (coef_valid_in && slot_free) begin
                  idx <= idx_next;
                  if (coef_zero) begin
                     if (idx_last) begin
                        sym_valid_out <= 1'b1;
                        sym_run_out   <= 4'd0;
                        sym_size_out  <= 4'd0;
                        sym_amp_out   <= 10'd0;
                        sym_last_out  <= 1'b1;
                        run           <= 6'd0;
                     end else begin
                        run <= 6'(run + 6'd1);
                     end
                  end else if (run < 6'd16) begin
                     sym_valid_out <= 1'b1;
                     sym_run_out   <= run[3:0];
                     sym_size_out  <= cur_size;
                     sym_amp_out   <= cur_amp;
                     sym_last_out  <= idx_last;
                     run           <= 6'd0;
                  end else begin
                     pend_size <= cur_size;
                     pend_amp  <= cur_amp;
                     pend_last <= idx_last;
                     state     <= S_ZRL;
                  end
               end
            end
            S_ZRL: begin
               if (slot_free) begin
                  sym_valid_out <= 1'b1;
                  sym_run_out   <= 4'd15;
                  sym_size_out  <= 4'd0;
                  sym_amp_out   <= 10'd0;
                  sym_last_out  <= 1'b0;
                  run           <= 6'(run - 6'd16);
                  if (run < 6'd32) state <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (slot_free) begin
                  sym_valid_out <= 1'b1;
                  sym_run_out   <= run[3:0];
                  sym_size_out  <= pend_size;
                  sym_amp_out   <= pend_amp;
                  sym_last_out  <= pend_last;
                  run           <= 6'd0;
                  state         <= S_ACCEPT;
               end
            end
            default: state <= S_ACCEPT;
         endcase
      end
   end

endmodule

// File: tb/tb_ac_rle_scheduler.sv
// tb/tb_ac_rle_scheduler.sv - scoreboard bench for ac_rle_scheduler
// Block-level reference model feeds an expected-symbol queue drained by a monitor.
module tb_ac_rle_scheduler;

   logic               clk_in = 1'b0;
   logic               rst_in_n = 1'b0;
   logic signed [10:0] coef_in = '0;
   logic               coef_valid_in = 1'b0;
   logic               coef_ready_out;
   logic [3:0]         sym_run_out;
   logic [3:0]         sym_size_out;
   logic [9:0]         sym_amp_out;
   logic               sym_last_out;
   logic               sym_valid_out;
   logic               sym_ready_in = 1'b1;
   logic [7:0]         lut_value_out;
   logic [7:0]         lut_count_out;

   typedef struct packed {
      logic [3:0] run;
      logic [3:0] size;
      logic [9:0] amp;
      logic       last;
   } sym_t;

   sym_t exp_q[$];
   int   cur_blk[63];
   int   n_cmp = 0;
   int   n_err = 0;
   int   rdy_mode = 0;
   bit   check_waits = 1'b0;
   bit   gaps = 1'b0;
   int   pend_k = 0;

   always #5 clk_in = ~clk_in;

   ac_rle_scheduler dut (
      .clk_in         (clk_in),
      .rst_in_n       (rst_in_n),
      .coef_in        (coef_in),
      .coef_valid_in  (coef_valid_in),
      .coef_ready_out (coef_ready_out),
      .sym_run_out    (sym_run_out),
      .sym_size_out   (sym_size_out),
      .sym_amp_out    (sym_amp_out),
      .sym_last_out   (sym_last_out),
      .sym_valid_out  (sym_valid_out),
      .sym_ready_in   (sym_ready_in),
      .lut_value_out  (lut_value_out),
      .lut_count_out  (lut_count_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bitlen(input int m);
      int s = 0;
      int x = m;
      while (x > 0) begin
         s++;
         x = x / 2;
      end
      return s;
   endfunction

   function automatic sym_t mk(input int r, input int s, input int a, input bit l);
      sym_t e;
      e.run  = 4'(r);
      e.size = 4'(s);
      e.amp  = 10'(a);
      e.last = l;
      return e;
   endfunction

   // Baseline JPEG AC run-length rules applied to the whole block at once.
   function automatic void model_block();
      int zr = 0;
      int v, m, s, a;
      for (int i = 0; i < 63; i++) begin
         v = cur_blk[i];
         if (v == 0) begin
            zr++;
         end else begin
            if (v == -1024) v = -1023;
            while (zr >= 16) begin
               exp_q.push_back(mk(15, 0, 0, 1'b0));
               zr -= 16;
            end
            m = (v < 0) ? -v : v;
            s = bitlen(m);
            a = (v > 0) ? v : v + (1 << s) - 1;
            exp_q.push_back(mk(zr, s, a, i == 62));
            zr = 0;
         end
      end
      if (cur_blk[62] == 0) exp_q.push_back(mk(0, 0, 0, 1'b1));
   endfunction

   initial begin
      forever begin
         @(negedge clk_in);
         case (rdy_mode)
            0:       sym_ready_in = 1'b1;
            1:       sym_ready_in = ($urandom_range(0, 3) != 0);
            default: sym_ready_in = 1'b0;
         endcase
      end
   end

   initial begin
      sym_t e;
      sym_t got;
      forever begin
         @(negedge clk_in);
         #2;
         if (rst_in_n && sym_valid_out && sym_ready_in) begin
            got = {sym_run_out, sym_size_out, sym_amp_out, sym_last_out};
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_symbol: got 0x%0h expected none at %0t", got, $time);
            end else begin
               e = exp_q.pop_front();
               check("symbol", {13'b0, got}, {13'b0, e});
               check("lut_value", {24'b0, lut_value_out}, {28'b0, e.run});
               check("lut_count", {24'b0, lut_count_out}, {28'b0, e.size});
            end
         end
      end
   end

   task automatic send_coef(input int v, output int waits, output bit ok);
      if (gaps && $urandom_range(0, 3) == 0) begin
         coef_valid_in = 1'b0;
         @(negedge clk_in);
      end
      coef_in       = 11'(v);
      coef_valid_in = 1'b1;
      waits         = 0;
      ok            = 1'b0;
      for (int t = 0; t < 300; t++) begin
         #1;
         if (coef_ready_out) begin
            ok = 1'b1;
            break;
         end
         waits++;
         @(negedge clk_in);
      end
      if (ok) begin
         @(negedge clk_in);
      end else begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: got no accept expected accept at %0t", $time);
      end
   endtask

   task automatic send_block(input bit push);
      int  zr = 0;
      int  w;
      int  exp_w;
      bit  ok;
      if (push) model_block();
      for (int i = 0; i < 63; i++) begin
         exp_w = (pend_k > 0) ? pend_k + 1 : 0;
         send_coef(cur_blk[i], w, ok);
         if (!ok) begin
            coef_valid_in = 1'b0;
            return;
         end
         if (check_waits) check("coef_wait", w, exp_w);
         if (cur_blk[i] == 0) begin
            pend_k = 0;
            zr++;
         end else begin
            pend_k = zr / 16;
            zr = 0;
         end
      end
      coef_valid_in = 1'b0;
   endtask

   task automatic clear_blk();
      for (int i = 0; i < 63; i++) cur_blk[i] = 0;
   endtask

   task automatic gen_random();
      int d, zp, v;
      d  = $urandom_range(0, 3);
      zp = (d == 0) ? 95 : (d == 1) ? 80 : (d == 2) ? 50 : 10;
      for (int i = 0; i < 63; i++) begin
         if ($urandom_range(0, 99) < zp) begin
            v = 0;
         end else begin
            case ($urandom_range(0, 7))
               0:       v = -1024;
               1, 2:    v = $urandom_range(1, 1023);
               default: v = $urandom_range(1, 7);
            endcase
            if (v > 0 && $urandom_range(0, 1) == 1) v = -v;
         end
         cur_blk[i] = v;
      end
   endtask

   task automatic stall_probe();
      sym_t e;
      repeat (12) @(negedge clk_in);
      #2;
      rdy_mode = 2;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_in);
         #2;
         check("stall_valid", {31'b0, sym_valid_out}, 32'd1);
         check("stall_coef_ready", {31'b0, coef_ready_out}, 32'd0);
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            check("stall_hold", {13'b0, sym_run_out, sym_size_out, sym_amp_out, sym_last_out},
                  {13'b0, e});
         end
      end
      rdy_mode = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  w;
      bit  ok;
      repeat (3) @(negedge clk_in);
      check("rst_hold_valid", {31'b0, sym_valid_out}, 32'd0);
      rst_in_n = 1'b1;
      #1;
      check("rst_valid", {31'b0, sym_valid_out}, 32'd0);
      check("rst_sym", {13'b0, sym_run_out, sym_size_out, sym_amp_out, sym_last_out}, 32'd0);
      check("rst_lut", {16'b0, lut_value_out, lut_count_out}, 32'd0);
      check("rst_coef_ready", {31'b0, coef_ready_out}, 32'd1);
      @(negedge clk_in);

      check_waits = 1'b1;
      clear_blk();
      send_block(1'b1);
      clear_blk();
      cur_blk[0] = 5;
      cur_blk[1] = -3;
      send_block(1'b1);
      clear_blk();
      cur_blk[39] = 1;
      send_block(1'b1);
      clear_blk();
      cur_blk[15] = -1024;
      for (int i = 16; i < 63; i++) cur_blk[i] = 1;
      send_block(1'b1);
      clear_blk();
      cur_blk[16] = 2;
      send_block(1'b1);
      clear_blk();
      cur_blk[62] = -700;
      send_block(1'b1);

      check_waits = 1'b0;
      for (int i = 0; i < 63; i++) begin
         cur_blk[i] = $urandom_range(1, 50);
         if ($urandom_range(0, 1) == 1) cur_blk[i] = -cur_blk[i];
      end
      fork
         send_block(1'b1);
         stall_probe();
      join
      repeat (3) @(negedge clk_in);

      // Park a ZRL in the output register, then reset while the FSM is mid-ZRL.
      rdy_mode = 2;
      @(negedge clk_in);
      for (int i = 0; i < 48; i++) begin
         send_coef((i == 47) ? 3 : 0, w, ok);
         if (!ok) break;
      end
      coef_valid_in = 1'b0;
      @(negedge clk_in);
      #1;
      check("zrl_parked_valid", {31'b0, sym_valid_out}, 32'd1);
      check("zrl_parked_run", {28'b0, sym_run_out}, 32'd15);
      check("zrl_coef_ready", {31'b0, coef_ready_out}, 32'd0);
      rst_in_n = 1'b0;
      #1;
      check("midrst_valid", {31'b0, sym_valid_out}, 32'd0);
      check("midrst_sym", {13'b0, sym_run_out, sym_size_out, sym_amp_out, sym_last_out}, 32'd0);
      check("midrst_lut", {16'b0, lut_value_out, lut_count_out}, 32'd0);
      @(negedge clk_in);
      rst_in_n = 1'b1;
      rdy_mode = 0;
      pend_k   = 0;
      #1;
      check("post_rst_coef_ready", {31'b0, coef_ready_out}, 32'd1);
      @(negedge clk_in);
      check_waits = 1'b1;
      clear_blk();
      cur_blk[20] = -2;
      cur_blk[55] = 9;
      send_block(1'b1);

      check_waits = 1'b0;
      rdy_mode    = 1;
      gaps        = 1'b1;
      for (int b = 0; b < 20; b++) begin
         gen_random();
         send_block(1'b1);
      end
      gaps     = 1'b0;
      rdy_mode = 0;
      for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(negedge clk_in);
      repeat (3) @(negedge clk_in);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
